// File: rtl/mem_access_unit.sv
// Initiator side of the RV32I memory port: arbitrates fetch and load/store
// requests onto the single memory port and returns responses.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        if_error,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_error,
  output logic        write_mem,
  output logic [2:0]  funct3,
  output logic [31:0] write_address,
  output logic [31:0] read_address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, STORE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic        src_fetch_q;

  logic        d_take;
  logic        if_take;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic        req_ok;

  // Fetches travel as word accesses, so the word alignment rule covers them.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lsb);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = !lsb[0];
      3'b010:  ok = (lsb == 2'b00);
      3'b100:  ok = !we;
      3'b101:  ok = !we && !lsb[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Grants are combinational so a request can be taken in the same cycle a
  // response is presented; data always wins over fetch.
  assign d_ready  = (state == IDLE) && !reset;
  assign if_ready = (state == IDLE) && !reset && !d_req;

  assign d_take   = d_req && d_ready;
  assign if_take  = if_req && if_ready;
  assign req_we   = d_take && d_we;
  assign req_f3   = d_take ? d_funct3 : 3'b010;
  assign req_addr = d_take ? d_addr : if_addr;
  assign req_ok   = access_legal(req_we, req_f3, req_addr[1:0]);

  assign read_address  = addr_q;
  assign write_address = addr_q;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      src_fetch_q <= 1'b0;
      funct3      <= 3'b010;
      write_mem   <= 1'b0;
      write_data  <= '0;
      if_valid    <= 1'b0;
      if_error    <= 1'b0;
      if_instr    <= '0;
      d_valid     <= 1'b0;
      d_error     <= 1'b0;
      d_rdata     <= '0;
    end else begin
      if_valid <= 1'b0;
      if_error <= 1'b0;
      d_valid  <= 1'b0;
      d_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_take || if_take) begin
            if (req_ok) begin
              addr_q      <= req_addr;
              funct3      <= req_f3;
              src_fetch_q <= if_take;
              if (req_we) begin
                write_data <= d_wdata;
                write_mem  <= 1'b1;
                state      <= STORE;
              end else begin
                state <= RD_ADDR;
              end
            end else if (if_take) begin
              if_valid <= 1'b1;
              if_error <= 1'b1;
              if_instr <= '0;
            end else begin
              d_valid <= 1'b1;
              d_error <= 1'b1;
              d_rdata <= '0;
            end
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          state <= IDLE;
          if (src_fetch_q) begin
            if_valid <= 1'b1;
            if_instr <= read_data;
          end else begin
            d_valid <= 1'b1;
            d_rdata <= read_data;
          end
        end
        STORE: begin
          state     <= IDLE;
          write_mem <= 1'b0;
          d_valid   <= 1'b1;
          d_rdata   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: behavioural memory with registered
// reads and extension, expected responses queued at issue and popped on valid.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ready, if_valid, if_error;
  logic [31:0] if_addr, if_instr;
  logic        d_req, d_we, d_ready, d_valid, d_error;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address, read_address, write_data, read_data;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;

  typedef struct packed {
    logic        fetch;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [logic [29:0]];
  logic [7:0]  led, red, green, blue;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_error(if_error),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_error(d_error),
    .write_mem(write_mem), .funct3(funct3), .write_address(write_address),
    .read_address(read_address), .write_data(write_data),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
  endfunction

  // Memory model: byte-lane writes, registered extended reads, LED peripheral
  // mirrored from the top word.
  always @(posedge clk) begin : mem_model
    logic [31:0] w, s;
    int          b;
    if (write_mem) begin
      w = rd_word(write_address);
      b = int'(write_address[1:0]);
      case (funct3[1:0])
        2'b00:   w[8*b +: 8] = write_data[7:0];
        2'b01:   w[16*(b/2) +: 16] = write_data[15:0];
        default: w = write_data;
      endcase
      mem[write_address[31:2]] = w;
      if (write_address[31:2] == 30'h3FFFFFFF) {led, red, green, blue} = w;
      wr_cnt++;
    end
    w = rd_word(read_address);
    s = w >> (8 * int'(read_address[1:0]));
    case (funct3)
      3'b000:  read_data <= {{24{s[7]}}, s[7:0]};
      3'b001:  read_data <= {{16{s[15]}}, s[15:0]};
      3'b010:  read_data <= w;
      3'b100:  read_data <= {24'h0, s[7:0]};
      3'b101:  read_data <= {16'h0, s[15:0]};
      default: read_data <= 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    check({tag, " pending"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.fetch) begin
        check({tag, " if_valid"}, if_valid, 1);
        check({tag, " d_valid"}, d_valid, 0);
        check({tag, " if_error"}, if_error, e.err);
        check({tag, " if_instr"}, if_instr, e.data);
      end else begin
        check({tag, " d_valid"}, d_valid, 1);
        check({tag, " if_valid"}, if_valid, 0);
        check({tag, " d_error"}, d_error, e.err);
        check({tag, " d_rdata"}, d_rdata, e.data);
      end
    end
  endtask

  // Called just after the edge starting cycle first_c; returns at the
  // negedge of the response cycle.
  task automatic wait_resp(input string tag, input int first_c, input int lat);
    bit found = 1'b0;
    for (int c = first_c; c <= first_c + 8 && !found; c++) begin
      @(negedge clk);
      if (d_valid || if_valid) begin
        found = 1'b1;
        check({tag, " latency"}, c, lat);
        pop_compare(tag);
      end else begin
        @(posedge clk); #1;
      end
    end
    check({tag, " responded"}, 32'(found), 1);
  endtask

  // One complete access issued from an IDLE cycle; returns one cycle after
  // the response cycle.
  task automatic op(input string tag, input bit fetch, input bit we,
                    input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata, input bit err,
                    input logic [31:0] data);
    int lat;
    lat = err ? 1 : (fetch ? 3 : (we ? 2 : 3));
    sb.push_back('{fetch: fetch, err: err, data: data});
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    end
    @(negedge clk);
    check({tag, " ready"}, fetch ? if_ready : d_ready, 1);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
    d_funct3 = 3'($urandom); d_we = 1'($urandom);
    wait_resp(tag, 1, lat);
    if (err) begin
      check({tag, " no write"}, write_mem, 0);
      check({tag, " still idle"}, d_ready, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic watch_silent(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (d_valid || if_valid) seen++;
    end
    check({tag, " no response"}, seen, 0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w0;
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
    mem[30'h4]  = 32'h00500093;
    mem[30'hC0] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst d_ready", d_ready, 0);
    check("rst if_ready", if_ready, 0);
    check("rst write_mem", write_mem, 0);
    check("rst funct3", funct3, 3'b010);
    check("rst read_address", read_address, 0);
    check("rst write_address", write_address, 0);
    check("rst write_data", write_data, 0);
    check("rst valids", {if_valid, if_error, d_valid, d_error}, 0);
    check("rst if_instr", if_instr, 0);
    check("rst d_rdata", d_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fetch with address/funct3 hold checks across both read cycles.
    sb.push_back('{fetch: 1'b1, err: 1'b0, data: 32'h00500093});
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("fetch if_ready", if_ready, 1);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = 32'h6;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check($sformatf("fetch c%0d read_address", c), read_address, 32'h10);
      check($sformatf("fetch c%0d funct3", c), funct3, 3'b010);
      @(posedge clk); #1;
    end
    wait_resp("fetch", 3, 3);
    @(posedge clk); #1;

    // Store then sub-word loads issued straight after the store response.
    w0 = wr_cnt;
    op("sw 100", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    check("sw single write", wr_cnt - w0, 1);
    op("lb 103",  0, 0, 3'b000, 32'h103, 0, 0, 32'hFFFFFFDE);
    op("lhu 102", 0, 0, 3'b101, 32'h102, 0, 0, 32'h0000DEAD);
    op("lh 100",  0, 0, 3'b001, 32'h100, 0, 0, 32'hFFFFBEEF);
    op("lbu 101", 0, 0, 3'b100, 32'h101, 0, 0, 32'h000000BE);
    op("sb 101",  0, 1, 3'b000, 32'h101, 32'h12345655, 0, 32'h0);
    op("lw 100",  0, 0, 3'b010, 32'h100, 0, 0, 32'hDEAD55EF);

    // Top-of-memory peripheral word.
    op("sw fffffffc", 0, 1, 3'b010, 32'hFFFFFFFC, 32'h80402010, 0, 32'h0);
    op("lw fffffffc", 0, 0, 3'b010, 32'hFFFFFFFC, 0, 0, 32'h80402010);
    check("led duty", led, 8'h80);
    check("red duty", red, 8'h40);
    check("green duty", green, 8'h20);
    check("blue duty", blue, 8'h10);

    // Illegal and misaligned requests.
    w0 = wr_cnt;
    op("lw 102 misaligned", 0, 0, 3'b010, 32'h102, 0, 1, 32'h0);
    op("sh 101 misaligned", 0, 1, 3'b001, 32'h101, 32'hFFFF, 1, 32'h0);
    op("store f3=100",      0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0);
    op("load f3=011",       0, 0, 3'b011, 32'h100, 0, 1, 32'h0);
    op("fetch 6",           1, 0, 3'b010, 32'h6, 0, 1, 32'h0);
    check("errors no writes", wr_cnt - w0, 0);
    op("lw 100 unchanged",  0, 0, 3'b010, 32'h100, 0, 0, 32'hDEAD55EF);

    // Simultaneous requests: data first, fetch taken in the data response cycle.
    sb.push_back('{fetch: 1'b0, err: 1'b0, data: 32'hCAFEF00D});
    sb.push_back('{fetch: 1'b1, err: 1'b0, data: 32'h00500093});
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("both d_ready", d_ready, 1);
    check("both if_ready", if_ready, 0);
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_resp("both data", 1, 3);
    check("both fetch granted", if_ready, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
    wait_resp("both fetch", 1, 3);
    @(posedge clk); #1;

    // Reset during RD_DATA of a load.
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h300;
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst rd d_valid", d_valid, 0);
    check("rst rd d_rdata", d_rdata, 0);
    check("rst rd read_address", read_address, 0);
    check("rst rd funct3", funct3, 3'b010);
    check("rst rd idle", d_ready, 1);
    @(posedge clk); #1;
    watch_silent("rst rd", 5);

    // Reset during STORE.
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h400; d_wdata = 32'h33333333;
    @(posedge clk); #1;
    d_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst st write_mem", write_mem, 0);
    check("rst st d_valid", d_valid, 0);
    check("rst st write_data", write_data, 0);
    check("rst st write_address", write_address, 0);
    @(posedge clk); #1;
    watch_silent("rst st", 5);

    // Reset in the acceptance cycle: the store never happens.
    op("sw 200", 0, 1, 3'b010, 32'h200, 32'h11111111, 0, 32'h0);
    reset = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h200; d_wdata = 32'h22222222;
    @(negedge clk);
    check("rst accept d_ready", d_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0; d_req = 1'b0;
    watch_silent("rst accept", 3);
    op("lw 200 unchanged", 0, 0, 3'b010, 32'h200, 0, 0, 32'h11111111);

    check("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
